// File: rtl/game_sequencer.sv
// game_sequencer: round flow controller for the flappy-box datapath.
// Walks IDLE -> PLAYING -> DYING -> GAME_OVER and generates the frame tick
// and movement enable. Scores pipes as they pass the box column (two BCD
// digits, saturating at 99) and pulses clear_collision when a round starts.
// Optional feature macro: HISCORE_EN. When it is defined, the best score is
// kept across rounds. When it is undefined, hiscore is tied to zero.
module game_sequencer #(
  parameter int unsigned FRAME_DIV    = 833333,
  parameter int unsigned DEATH_FRAMES = 30,
  parameter int unsigned BOX_X        = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       key_press,
  input  logic       collided,
  input  logic [7:0] pipe_x1,
  input  logic [7:0] pipe_x2,
  input  logic [7:0] pipe_x3,
  output logic [1:0] state,
  output logic       move_en,
  output logic       frame_tick,
  output logic       flap,
  output logic       clear_collision,
  output logic [7:0] score,
  output logic [7:0] hiscore
);

  localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_MAX = FW'(FRAME_DIV - 1);
  localparam logic [DW-1:0] DEATH_MAX = DW'(DEATH_FRAMES - 1);
  localparam logic [7:0]    SCORE_X   = 8'(BOX_X - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_PLAYING   = 2'b01,
    S_DYING     = 2'b10,
    S_GAME_OVER = 2'b11
  } state_t;

  state_t          cur;
  logic            key_prev;
  logic            key_rise;
  logic            coll_q;
  logic [FW-1:0]   frame_cnt;
  logic [DW-1:0]   death_cnt;
  logic            frame_wrap;
  logic            pipe_hit;
  logic            death_done;

  assign state      = cur;
  assign frame_wrap = (frame_cnt == FRAME_MAX);
  assign pipe_hit   = (pipe_x1 == SCORE_X) | (pipe_x2 == SCORE_X) | (pipe_x3 == SCORE_X);
  assign death_done = (cur == S_DYING) && frame_tick && (death_cnt == DEATH_MAX);

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {4'(v[7:4] + 4'd1), 4'd0};
    else
      r = {v[7:4], 4'(v[3:0] + 4'd1)};
    return r;
  endfunction

  // Round state machine, frame/death counters, score and output pulses.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      cur             <= S_IDLE;
      key_prev        <= 1'b1;
      key_rise        <= 1'b0;
      coll_q          <= 1'b0;
      frame_cnt       <= '0;
      death_cnt       <= '0;
      move_en         <= 1'b0;
      frame_tick      <= 1'b0;
      flap            <= 1'b0;
      clear_collision <= 1'b0;
      score           <= 8'h00;
    end else begin
      key_prev        <= key_press;
      key_rise        <= key_press & ~key_prev;
      coll_q          <= collided;
      frame_tick      <= 1'b0;
      flap            <= 1'b0;
      clear_collision <= 1'b0;
      case (cur)
        S_IDLE, S_GAME_OVER: begin
          frame_cnt <= '0;
          move_en   <= 1'b0;
          if (key_rise) begin
            cur             <= S_PLAYING;
            move_en         <= 1'b1;
            clear_collision <= 1'b1;
            score           <= 8'h00;
          end
        end
        S_PLAYING: begin
          frame_cnt  <= frame_wrap ? '0 : frame_cnt + 1'b1;
          frame_tick <= frame_wrap;
          if (frame_tick && !collided && pipe_hit)
            score <= bcd_inc(score);
          if (coll_q) begin
            cur       <= S_DYING;
            move_en   <= 1'b0;
            death_cnt <= '0;
          end else begin
            move_en <= 1'b1;
            flap    <= key_rise;
          end
        end
        S_DYING: begin
          move_en <= 1'b0;
          if (death_done) begin
            cur       <= S_GAME_OVER;
            frame_cnt <= '0;
          end else begin
            frame_cnt  <= frame_wrap ? '0 : frame_cnt + 1'b1;
            frame_tick <= frame_wrap;
            if (frame_tick)
              death_cnt <= death_cnt + 1'b1;
          end
        end
        default: cur <= S_IDLE;
      endcase
    end
  end

`ifdef HISCORE_EN
  // Best score, captured as a round ends; only resetn clears it.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn)
      hiscore <= 8'h00;
    else if (death_done && (score > hiscore))
      hiscore <= score;
  end
`else
  assign hiscore = 8'h00;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: event-level reference model compared every cycle,
// plus directed checks with hand-computed values (FRAME_DIV=4, DEATH_FRAMES=2).
module tb_game_sequencer;

  localparam int FD = 4;
  localparam int DF = 2;
  localparam int BX = 4;
`ifdef HISCORE_EN
  localparam logic [7:0] EXP_HI1 = 8'h05;
`else
  localparam logic [7:0] EXP_HI1 = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       key_press;
  logic       collided;
  logic [7:0] pipe_x1, pipe_x2, pipe_x3;
  logic [1:0] state;
  logic       move_en, frame_tick, flap, clear_collision;
  logic [7:0] score, hiscore;

  game_sequencer #(.FRAME_DIV(FD), .DEATH_FRAMES(DF), .BOX_X(BX)) dut (
    .CLOCK_50(clk), .resetn(resetn), .key_press(key_press), .collided(collided),
    .pipe_x1(pipe_x1), .pipe_x2(pipe_x2), .pipe_x3(pipe_x3),
    .state(state), .move_en(move_en), .frame_tick(frame_tick), .flap(flap),
    .clear_collision(clear_collision), .score(score), .hiscore(hiscore)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: decimal score, cycles-since-round-start for ticks,
  // key/collision decisions acting one cycle after they are sampled.
  int m_state, m_score, m_hi, age, deaths;
  bit m_move, m_tick, m_flap, m_clr;
  bit kp, rise_p, coll_p, model_valid = 0;
  bit hit, prev_tick, rise_use, coll_use;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_state = 0; m_score = 0; m_hi = 0; age = 0; deaths = 0;
      m_move = 0; m_tick = 0; m_flap = 0; m_clr = 0;
      kp = 1; rise_p = 0; coll_p = 0; model_valid = 1;
    end else begin
      hit = (pipe_x1 == 8'(BX - 1)) || (pipe_x2 == 8'(BX - 1)) || (pipe_x3 == 8'(BX - 1));
      prev_tick = m_tick;
      rise_use = rise_p;
      coll_use = coll_p;
      rise_p = key_press && !kp;
      kp = key_press;
      coll_p = collided;
      m_clr = 0; m_flap = 0; m_tick = 0;
      case (m_state)
        0, 3: if (rise_use) begin
          m_state = 1; m_move = 1; m_clr = 1; m_score = 0; age = 0;
        end
        1: begin
          age++;
          m_tick = (age % FD == 0);
          if (prev_tick && !collided && hit && m_score < 99) m_score++;
          if (coll_use) begin m_state = 2; m_move = 0; deaths = 0; end
          else m_flap = rise_use;
        end
        default: begin
          if (prev_tick) deaths++;
          if (deaths == DF) begin
            m_state = 3;
`ifdef HISCORE_EN
            if (m_score > m_hi) m_hi = m_score;
`endif
          end else begin
            age++;
            m_tick = (age % FD == 0);
          end
        end
      endcase
    end
  end

  int flap_cnt = 0, clr_cnt = 0, dying_ticks = 0;
  logic [21:0] got_v, exp_v;

  // Per-cycle compare against the model and pulse counters for directed checks.
  always @(negedge clk) begin
    if (model_valid) begin
      got_v = {state, move_en, frame_tick, flap, clear_collision, score, hiscore};
      exp_v = {2'(m_state), m_move, m_tick, m_flap, m_clr, to_bcd(m_score), to_bcd(m_hi)};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL model_cycle t=%0t got {st,mv,tk,fl,clr,sc,hi}=%h expected %h", $time, got_v, exp_v);
      end
      if (flap === 1'b1) flap_cnt++;
      if (clear_collision === 1'b1) clr_cnt++;
      if (frame_tick === 1'b1 && state == 2'b10) dying_ticks++;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < budget);
    tests++;
    if (frame_tick !== 1'b1) begin
      fails++;
      $display("FAIL wait_tick got no tick expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      step();
      n++;
    end
    tests++;
    if (state !== s) begin
      fails++;
      $display("FAIL wait_state got %b expected %b", state, s);
    end
  endtask

  task automatic press();
    key_press = 1'b1;
    step();
    key_press = 1'b0;
    step();
  endtask

  int c0, f0, d0;

  initial begin
    resetn = 1'b0; key_press = 1'b1; collided = 1'b0;
    pipe_x1 = 8'd200; pipe_x2 = 8'd200; pipe_x3 = 8'd200;
    repeat (3) step();
    check("reset_state", 8'(state), 8'h00);
    check("reset_score", score, 8'h00);
    resetn = 1'b1;
    repeat (4) step();
    check("held_key_no_start", 8'(state), 8'h00);
    key_press = 1'b0;
    repeat (2) step();

    // Round 1: start latency and single clear pulse
    c0 = clr_cnt;
    key_press = 1'b1;
    step();
    check("start_not_yet", 8'(state), 8'h00);
    step();
    check("start_state", 8'(state), 8'h01);
    check("start_clear", 8'(clear_collision), 8'h01);
    check("start_move_en", 8'(move_en), 8'h01);
    step();
    key_press = 1'b0;
    check("clear_drops", 8'(clear_collision), 8'h00);
    repeat (3) step();
    check("one_clear_pulse", 8'(clr_cnt - c0), 8'h01);

    // Scoring: three ticks with pipe_x1 at the box column
    pipe_x1 = 8'd3;
    repeat (3) wait_tick(20);
    step();
    pipe_x1 = 8'd200;
    step();
    check("score_03", score, 8'h03);
    // Two pipes matching on one tick add only one
    pipe_x1 = 8'd3; pipe_x3 = 8'd3;
    wait_tick(20);
    step();
    pipe_x1 = 8'd200; pipe_x3 = 8'd200;
    step();
    check("score_multi_04", score, 8'h04);
    pipe_x2 = 8'd3;
    wait_tick(20);
    step();
    pipe_x2 = 8'd200;
    step();
    check("score_05", score, 8'h05);

    // Flap pulses in PLAYING
    f0 = flap_cnt;
    repeat (3) begin
      key_press = 1'b1; step(); step();
      key_press = 1'b0; step(); step();
    end
    step(); step();
    check("flaps_playing", 8'(flap_cnt - f0), 8'h03);

    // Collision during a tick cycle with a scoring pipe
    wait_tick(20);
    repeat (4) step();
    collided = 1'b1; pipe_x2 = 8'd3;
    d0 = dying_ticks;
    step(); step();
    check("dying_state", 8'(state), 8'h02);
    check("dying_move_en", 8'(move_en), 8'h00);
    collided = 1'b0; pipe_x2 = 8'd200;
    f0 = flap_cnt;
    repeat (3) begin
      key_press = 1'b1; step();
      key_press = 1'b0; step();
    end
    wait_state(2'b11, 20);
    check("no_flap_dying", 8'(flap_cnt - f0), 8'h00);
    check("dying_two_ticks", 8'(dying_ticks - d0), 8'h02);
    check("score_kept_05", score, 8'h05);
    check("hiscore_round1", hiscore, EXP_HI1);

    // Round 2: restart from GAME_OVER, end with 03
    press();
    check("restart_state", 8'(state), 8'h01);
    check("restart_score", score, 8'h00);
    pipe_x1 = 8'd3;
    repeat (3) wait_tick(20);
    step();
    pipe_x1 = 8'd200;
    step();
    check("round2_score_03", score, 8'h03);
    collided = 1'b1;
    wait_state(2'b11, 40);
    collided = 1'b0;
    step();
    check("hiscore_round2", hiscore, EXP_HI1);

    // Round 3: run to saturation at 99, then reset while dying
    press();
    pipe_x1 = 8'd3;
    repeat (99) wait_tick(20);
    step(); step();
    check("score_99", score, 8'h99);
    wait_tick(20);
    step(); step();
    check("score_sat_99", score, 8'h99);
    pipe_x1 = 8'd200;
    collided = 1'b1;
    wait_state(2'b10, 20);
    collided = 1'b0;
    step();
    resetn = 1'b0;
    step();
    check("rst_state", 8'(state), 8'h00);
    check("rst_score", score, 8'h00);
    check("rst_tick", 8'(frame_tick), 8'h00);
    check("rst_hiscore", hiscore, 8'h00);
    resetn = 1'b1;
    repeat (4) step();
    check("idle_after_rst", 8'(state), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller for the flappy-box datapath. Sequences the round through idle, play, death-flash and game-over states. Generates the frame tick and movement enable that drive pipe scrolling and box physics, and issues the clear pulse that re-arms the collision detector. Scores pipes as they pass the box column and, optionally, tracks a high score. Sits between the key input, the collision detector, the pipe/box movers and the score display.

## Interface
Parameters:
- FRAME_DIV, 833333: CLOCK_50 cycles per frame tick (60 Hz).
- DEATH_FRAMES, 30: frame ticks spent in DYING before GAME_OVER.
- BOX_X, 4: fixed box column; a pipe scores when its x equals BOX_X-1.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- resetn  in  1  reset, synchronous, active-low.
- key_press  in  1  raw level of the flap/start key, already synchronised to CLOCK_50.
- collided  in  1  collision flag from the collision detector.
- pipe_x1, pipe_x2, pipe_x3  in  8  current pipe x coordinates.
- state  out  2  IDLE=00, PLAYING=01, DYING=10, GAME_OVER=11.
- move_en  out  1  high while in PLAYING.
- frame_tick  out  1  one-cycle pulse every FRAME_DIV cycles in PLAYING or DYING.
- flap  out  1  one-cycle pulse per key rising edge while in PLAYING.
- clear_collision  out  1  one-cycle pulse on round start; drives the detector's key_press.
- score  out  8  two BCD digits, [7:4] tens, [3:0] ones.
- hiscore  out  8  BCD high score (see Configuration).

## Operation
- Key edge: key_prev register, reset to 1. Rising edge = key_press & ~key_prev. A key held through reset therefore never starts a round.
- IDLE: rising edge -> PLAYING. On entry: score cleared, frame counter cleared, clear_collision pulsed.
- PLAYING: collided=1 -> DYING. Otherwise a rising edge pulses flap.
- PLAYING, scoring: on a frame_tick cycle with collided=0, score += 1 if any of pipe_x1..3 equals BOX_X-1. The increment is at most 1 per tick, even if several pipes match.
- DYING: counts frame ticks. On the DEATH_FRAMES-th tick -> GAME_OVER. Key edges are ignored.
- GAME_OVER: rising edge -> PLAYING with the same entry actions as from IDLE.
- Frame counter: width $clog2(FRAME_DIV). Runs only in PLAYING and DYING, wraps FRAME_DIV-1 -> 0, and frame_tick is high on the wrap cycle. It holds 0 in IDLE and GAME_OVER.
- Death counter: cleared on DYING entry. No wrap is needed because the state is left when the count is reached.
- BCD arithmetic: ones 9 -> 0 carries into tens. 99 saturates at 99.
- Collision and a scoring pipe in the same cycle: collision wins, no increment, next state DYING.
- resetn low mid-round: next edge forces IDLE and clears all counters and outputs, regardless of state.

## Timing
- All outputs are registered. Reset values: state=00, move_en=0, frame_tick=0, flap=0, clear_collision=0, score=00, hiscore=00.
- Key high first sampled at edge N (prev low) -> state=01, move_en=1, clear_collision=1 after edge N+1. clear_collision is low again after N+2.
- flap: key edge sampled at N -> flap high for the cycle following edge N+1.
- collided sampled high at N -> state=10, move_en=0 after N+1.
- First frame_tick after PLAYING entry: FRAME_DIV cycles after the entry edge.
- score updates on the edge after the frame_tick cycle on which the match was sampled.

## Configuration
- HISCORE_EN defined:
  - hiscore register loads score on the DYING -> GAME_OVER transition if score > hiscore (BCD compare).
  - It survives round restarts and is cleared only by resetn.
- HISCORE_EN undefined: hiscore is tied to 8'h00 and no compare logic is built.

## Test plan
Bench parameters: FRAME_DIV=4, DEATH_FRAMES=2, BOX_X=4.
- Reset with key held, release, then press: no start while held; state 00 -> 01 one cycle after the press edge, with a single clear_collision pulse.
- PLAYING, pipe_x1=3 across 3 ticks, collided=0: score 00 -> 03. Preload 99 plus one match -> stays 99.
- Key toggled 3 times in PLAYING: exactly 3 flap pulses. Same toggles in DYING: 0 pulses, state unchanged.
- collided=1 on a tick cycle where pipe_x2=3: no score change. State 10, then 11 after 2 further ticks (8 cycles).
- resetn low for 1 cycle while in DYING: next cycle state=00, score=00, frame_tick=0, and with HISCORE_EN, hiscore=00.
- HISCORE_EN: rounds ending with scores 05 then 03 -> hiscore 05 after both. Without the macro, hiscore stays 00 throughout.
